// File: rtl/imem_boot_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them
// to instruction memory, holding the core in reset until the program is in place.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q,     state_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic [ADDR_W-1:0] waddr_q,     waddr_d;
    logic [1:0]        byte_idx_q,  byte_idx_d;
    logic [31:0]       shift_q,     shift_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              err_q,       err_d;
    logic              last_word_s;

    // The final word is reached when the write address equals count-1; count is never 0 here.
    assign last_word_s = ({1'b0, waddr_q} == (count_q - CNT_ONE));

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        waddr_d     = waddr_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        cpu_reset_d = 1'b1;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    if (word_count == CNT_ZERO) begin
                        state_d = ST_RUN;
                    end else if (word_count > MAX_WORDS) begin
                        err_d = 1'b1;
                    end else begin
                        count_d    = word_count;
                        err_d      = 1'b0;
                        waddr_d    = ADDR_ZERO;
                        byte_idx_d = 2'd0;
                        shift_d    = 32'h0000_0000;
                        state_d    = ST_RECV;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECV: begin
                if (in_valid) begin
                    shift_d    = {shift_q[23:0], in_byte};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = waddr_q;
                        wdata_d = {shift_q[23:0], in_byte};
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
                    state_d = ST_RUN;
                end else begin
                    waddr_d = waddr_q + ADDR_ONE;
                    state_d = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_RUN) begin
            cpu_reset_d = 1'b0;
        end else begin
            cpu_reset_d = 1'b1;
        end
    end

    // State and registered outputs; reset abandons any load in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= CNT_ZERO;
            waddr_q     <= ADDR_ZERO;
            byte_idx_q  <= 2'd0;
            shift_q     <= 32'h0000_0000;
            we_q        <= 1'b0;
            addr_q      <= ADDR_ZERO;
            wdata_q     <= 32'h0000_0000;
            cpu_reset_q <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            waddr_q     <= waddr_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            err_q       <= err_d;
        end
    end

    assign in_ready   = (state_q == ST_RECV);
    assign busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign done       = (state_q == ST_RUN);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as bytes are
// driven and matched against every imem_we strobe seen by the monitor.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    int n_vec = 0;
    int n_mis = 0;
    logic [39:0] exp_q[$];

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 64'(imem_addr), 64'hFFFF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(e[39:32]));
                check("wr_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        step();
    endtask

    task automatic do_start(input logic [ADDR_W:0] wc);
        start      = 1'b1;
        word_count = wc;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (in_ready !== 1'b1) check("rdy_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        reset      = 1'b1;
        start      = 1'b0;
        word_count = '0;
        in_byte    = 8'h00;
        in_valid   = 1'b0;
        #2;
        apply_reset();
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'({in_ready, busy, done}), 64'd0);

        // Two-word load with a 3-cycle stall after byte 2.
        exp_q.push_back({8'd0, 32'h2008_0005});
        exp_q.push_back({8'd1, 32'hAC09_0000});
        do_start(9'd2);
        check("recv_busy", 64'({in_ready, busy, done, cpu_reset}), 64'b1101);
        send_byte(8'h20);
        send_byte(8'h08);
        repeat (3) step();
        check("stall_hold", 64'({in_ready, busy, imem_we}), 64'b110);
        send_byte(8'h00);
        send_byte(8'h05);
        check("w0_lat", 64'(imem_we), 64'd1);
        check("w0_rdy", 64'(in_ready), 64'd0);
        send_word(32'hAC09_0000);
        check("w1_lat", 64'(imem_we), 64'd1);
        step();
        check("run_after", 64'({done, cpu_reset, busy, imem_we}), 64'b1000);

        // Rejected start in RUN keeps running, flags err.
        do_start(9'd257);
        check("run_rej", 64'({err, done, cpu_reset}), 64'b110);

        // Restart from RUN with one word.
        exp_q.push_back({8'd0, 32'h1234_5678});
        do_start(9'd1);
        check("rerun", 64'({cpu_reset, busy, err, done}), 64'b1100);
        send_word(32'h1234_5678);
        check("rerun_we", 64'(imem_we), 64'd1);
        step();
        check("rerun_done", 64'({done, cpu_reset}), 64'b10);

        // Zero-length load.
        apply_reset();
        do_start(9'd0);
        check("zero_run", 64'({done, cpu_reset, busy}), 64'b100);
        repeat (3) step();
        check("zero_hold", 64'({done, imem_we}), 64'b10);

        // Over-capacity start in IDLE, then a legal one.
        apply_reset();
        do_start(9'd257);
        check("idle_rej", 64'({err, busy, done, cpu_reset}), 64'b1001);
        step();
        check("err_sticky", 64'(err), 64'd1);
        exp_q.push_back({8'd0, 32'hDEAD_BEEF});
        do_start(9'd1);
        check("err_clear", 64'({err, busy}), 64'b01);
        send_word(32'hDEAD_BEEF);
        step();
        check("after_rej_done", 64'({done, cpu_reset}), 64'b10);

        // Asynchronous reset mid-word, then a clean reload.
        apply_reset();
        do_start(9'd1);
        send_byte(8'h55);
        send_byte(8'h66);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", 64'({cpu_reset, imem_we, busy, in_ready}), 64'b1000);
        @(posedge clk);
        #3;
        reset = 1'b1;
        step();
        exp_q.push_back({8'd0, 32'hA1B2_C3D4});
        do_start(9'd1);
        send_word(32'hA1B2_C3D4);
        step();
        check("reload_done", 64'({done, cpu_reset}), 64'b10);

        // Full-capacity load: last address is 2^ADDR_W-1 and no wrap.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            exp_q.push_back({b, b, ~b, b ^ 8'h5A, 8'hC3});
        end
        do_start(9'd256);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            w = {b, ~b, b ^ 8'h5A, 8'hC3};
            send_word(w);
        end
        check("full_last_addr", 64'(imem_addr), 64'hFF);
        step();
        check("full_done", 64'({done, cpu_reset, busy}), 64'b100);
        step();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle MIPS core.
- Receives a program as a byte stream over a valid/ready interface and packs each 4 bytes, big-endian, into one 32-bit instruction word.
- Writes the words to instruction memory at consecutive word addresses, starting at 0.
- Holds the core in reset until the load completes, then releases it to run.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets the block immediately, independent of clk.
- start  in  1  single-cycle request to begin a load; sampled in IDLE and RUN only.
- word_count  in  ADDR_W+1  number of words to load; latched on an accepted start.
- in_byte  in  8  stream data byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  block accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word being written.
- cpu_reset  out  1  active-high reset for the core; 1 holds the core.
- busy  out  1  1 in RECV or WRITE.
- done  out  1  1 in RUN.
- err  out  1  sticky flag: a start was rejected.

Behaviour:
- All outputs are registered, except in_ready, busy and done, which are decoded directly from the state.
- Reset (reset=0), asynchronously:
  - state=IDLE, cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, err=0.
  - Internal byte counter=0, word address=0, shift register=0.
- Reset mid-load abandons the load; words already written stay in memory.
- Accept rule: a byte is accepted only when in_valid=1 and in_ready=1 in the same cycle.
- IDLE:
  - in_ready=0, cpu_reset=1.
  - start with word_count=0: go to RUN next cycle.
  - start with word_count > 2^ADDR_W: set err=1, stay in IDLE.
  - Otherwise, start latches count, clears err, word address and byte index, and goes to RECV.
- RECV:
  - in_ready=1.
  - Each accepted byte does shift = {shift[23:0], in_byte}; the first byte lands in [31:24].
  - The byte index increments per accepted byte, wrapping 3 to 0.
  - The 4th accepted byte goes to WRITE next cycle.
  - in_valid=0 stalls indefinitely; partial words are held.
- WRITE:
  - Exactly one cycle: imem_we=1, imem_addr=word address, imem_wdata=assembled word. in_ready=0.
  - Next state: RUN if word address == count-1; else word address+1 and back to RECV.
- Throughput: at most one word per 5 cycles.
  - Write strobe appears 1 cycle after the 4th byte is accepted.
  - Next byte can be accepted 2 cycles after the 4th byte.
- RUN:
  - cpu_reset=0, registered: drops on the first cycle in RUN. in_ready=0.
  - start re-runs the IDLE decision, including the err check.
  - On an accepted start, cpu_reset returns to 1 in the same edge as the state change.
  - A rejected start sets err=1 and remains in RUN.
- start in RECV or WRITE is ignored.
- imem_we is 0 in every state except WRITE.
- word_count = 2^ADDR_W is legal: the final write uses imem_addr = 2^ADDR_W - 1, and the address never wraps.

Test Plan:
- Reset with outputs driven, then a start pulse with word_count=2 and bytes 20,08,00,05,AC,09,00,00 sent back-to-back → two writes: imem_addr=0 with imem_wdata=20080005, imem_addr=1 with AC090000. Then done=1 and cpu_reset=0, one cycle after the second write.
- In the same load, drop in_valid for 3 cycles after byte 2 → the same words are written, with the write delayed by 3 cycles; no spurious imem_we.
- word_count=0 → RUN one cycle after start; no imem_we ever; cpu_reset=0.
- ADDR_W=8, word_count=257 → err=1, state stays IDLE, cpu_reset=1. Then a start with word_count=1 clears err and the load proceeds.
- reset pulsed low asynchronously mid-cycle after 2 bytes of word 0 → cpu_reset=1 and imem_we=0 immediately. A fresh load then writes the correct word at address 0, with no stale bytes.
- In RUN, start with word_count=1 → cpu_reset=1 next cycle and busy=1. After 4 bytes, one write at address 0, then back to RUN.
